// File: rtl/bullet_pkg.sv
// Shared defaults and state encoding for the player bullet.
package bullet_pkg;

  localparam int DEF_BULLET_W     = 4;
  localparam int DEF_BULLET_H     = 12;
  localparam int DEF_BULLET_SPEED = 8;
  localparam int DEF_COOLDOWN     = 15;

  localparam int HRES     = 640;
  localparam int VRES     = 480;
  localparam int PADDLE_H = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/bullet.sv
// Player bullet: launch on fire, climbs one step per frame, retires on top edge or hit,
// then waits a fixed number of frames before another launch is allowed.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | no bullet; a fire edge arms fire_req, launch on next fsync
// ST_FLYING   | bullet moving up each fsync; hit or top edge retires it
// ST_COOLDOWN | frame counter runs down; IDLE on the fsync that sees zero
module bullet
  import bullet_pkg::*;
#(
  parameter int BULLET_W     = DEF_BULLET_W,
  parameter int BULLET_H     = DEF_BULLET_H,
  parameter int BULLET_SPEED = DEF_BULLET_SPEED,
  parameter int COOLDOWN     = DEF_COOLDOWN
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               fire,
  input  logic signed [11:0] paddle_center_x,
  input  logic               hit,
  output logic [2:0][7:0]    pixel,
  output logic               active,
  output logic signed [11:0] bullet_x,
  output logic signed [11:0] bullet_y,
  output logic               bullet_live
);

  localparam int CNT_W = $clog2(COOLDOWN + 2);
  localparam logic signed [11:0] Y0     = 12'(VRES - PADDLE_H - BULLET_H);
  localparam logic signed [11:0] SPEED  = 12'(BULLET_SPEED);
  localparam logic signed [12:0] HALF_W = 13'(BULLET_W / 2);
  localparam logic signed [12:0] HGT    = 13'(BULLET_H);

  state_t             state;
  logic               fire_d;
  logic               fire_req;
  logic [CNT_W-1:0]   cnt;
  logic               fire_rise;

  logic signed [12:0] bx13, by13, hp13, vp13;
  logic               in_box;

  assign fire_rise   = fire & ~fire_d;
  assign bullet_live = (state == ST_FLYING);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fire_d   <= 1'b0;
      fire_req <= 1'b0;
      cnt      <= '0;
      bullet_x <= '0;
      bullet_y <= '0;
    end else begin
      fire_d <= fire;
      case (state)
        ST_IDLE: begin
          if (fsync && (fire_req || fire_rise)) begin
            state    <= ST_FLYING;
            bullet_x <= paddle_center_x;
            bullet_y <= Y0;
            fire_req <= 1'b0;
          end else if (fire_rise) begin
            fire_req <= 1'b1;
          end
        end
        ST_FLYING: begin
          fire_req <= 1'b0;
          // A hit retires the bullet where it is, even on a frame boundary.
          if (hit) begin
            state <= ST_COOLDOWN;
            cnt   <= CNT_W'(COOLDOWN);
          end else if (fsync) begin
            if (bullet_y < SPEED) begin
              state <= ST_COOLDOWN;
              cnt   <= CNT_W'(COOLDOWN);
            end else begin
              bullet_y <= bullet_y - SPEED;
            end
          end
        end
        ST_COOLDOWN: begin
          fire_req <= 1'b0;
          if (fsync) begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Widen to 13 bits so bounds near the screen edges cannot wrap.
  assign bx13 = {bullet_x[11], bullet_x};
  assign by13 = {bullet_y[11], bullet_y};
  assign hp13 = {hpos[11], hpos};
  assign vp13 = {vpos[11], vpos};

  assign in_box = (hp13 >= bx13 - HALF_W) && (hp13 < bx13 + HALF_W) &&
                  (vp13 >= by13) && (vp13 < by13 + HGT);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      pixel  <= '0;
    end else begin
      active <= bullet_live && in_box;
      pixel  <= (bullet_live && in_box) ? {8'hFF, 8'hFF, 8'h00} : '0;
    end
  end

endmodule

// File: tb/tb_bullet.sv
// Directed bench for the bullet block: launch, flight, cooldown, hit, raster and reset.
module tb_bullet;

  logic               pixel_clk = 1'b0;
  logic               rst_n     = 1'b0;
  logic               fsync     = 1'b0;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               fire      = 1'b0;
  logic signed [11:0] paddle_center_x;
  logic               hit       = 1'b0;
  logic [2:0][7:0]    pixel;
  logic               active;
  logic signed [11:0] bullet_x;
  logic signed [11:0] bullet_y;
  logic               bullet_live;

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames;

  localparam int Y0 = 480 - 16 - 12;

  bullet dut (
    .pixel_clk       (pixel_clk),
    .rst_n           (rst_n),
    .fsync           (fsync),
    .hpos            (hpos),
    .vpos            (vpos),
    .fire            (fire),
    .paddle_center_x (paddle_center_x),
    .hit             (hit),
    .pixel           (pixel),
    .active          (active),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bullet_live     (bullet_live)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic frame();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    hpos = -12'sd100;
    vpos = -12'sd100;
    paddle_center_x = 12'sd320;

    #22;
    check("rst_live",   32'(bullet_live), 0);
    check("rst_x",      32'(bullet_x), 0);
    check("rst_y",      32'(bullet_y), 0);
    check("rst_active", 32'(active), 0);
    check("rst_pixel",  32'(pixel), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fire pulse, then launch on next fsync
    fire = 1'b1; tick(); fire = 1'b0; tick();
    check("no_fsync_live", 32'(bullet_live), 0);
    fsync = 1'b1; tick(); fsync = 1'b0;
    check("launch_live", 32'(bullet_live), 1);
    check("launch_x",    32'(bullet_x), 320);
    check("launch_y",    32'(bullet_y), Y0);

    paddle_center_x = 12'sd100;
    frame();
    check("step_y",   32'(bullet_y), Y0 - 8);
    check("frozen_x", 32'(bullet_x), 320);

    // Raster coverage around bullet at (320, 444)
    hpos = 12'sd318; vpos = 12'sd444; tick();
    check("act_left",   32'(active), 1);
    check("pix_left",   32'(pixel), 32'h00FFFF00);
    hpos = 12'sd322; tick();
    check("act_right",  32'(active), 0);
    check("pix_right",  32'(pixel), 0);
    hpos = 12'sd317; tick();
    check("act_left_out", 32'(active), 0);
    hpos = 12'sd321; vpos = 12'sd455; tick();
    check("act_bottom", 32'(active), 1);
    vpos = 12'sd456; tick();
    check("act_below",  32'(active), 0);
    hpos = -12'sd100; vpos = -12'sd100;

    // Free flight with fire toggling: no relaunch, retire at y=4
    n_frames = 0;
    for (int k = 0; k < 100 && bullet_live; k++) begin
      fire = (k % 3 != 0);
      tick();
      frame();
      n_frames++;
    end
    check("flight_frames", 32'(n_frames), 56);
    check("retire_y",      32'(bullet_y), 4);
    check("retire_live",   32'(bullet_live), 0);

    // Cooldown: 15 fsyncs with fire pulses, then 16th with a coincident edge
    fire = 1'b0; tick();
    for (int k = 0; k < 15; k++) begin
      fire = 1'b1; tick(); fire = 1'b0; tick();
      frame();
    end
    check("cd15_live", 32'(bullet_live), 0);
    fire = 1'b1; fsync = 1'b1; tick(); fsync = 1'b0; tick();
    check("cd16_live", 32'(bullet_live), 0);
    frame();
    check("held_no_edge", 32'(bullet_live), 0);
    fire = 1'b0; tick();
    fire = 1'b1; fsync = 1'b1; tick(); fsync = 1'b0;
    check("same_cycle_live", 32'(bullet_live), 1);
    check("same_cycle_x",    32'(bullet_x), 100);
    check("same_cycle_y",    32'(bullet_y), Y0);
    fire = 1'b0;

    // hit and fsync together
    frame();
    hit = 1'b1; fsync = 1'b1; tick(); hit = 1'b0; fsync = 1'b0;
    check("hit_live", 32'(bullet_live), 0);
    check("hit_y",    32'(bullet_y), Y0 - 8);

    // Relaunch then reset mid-flight
    for (int k = 0; k < 16; k++) frame();
    fire = 1'b1; tick(); fire = 1'b0;
    frame();
    check("relaunch_live", 32'(bullet_live), 1);
    hpos = 12'sd100; vpos = 12'sd460; tick();
    check("pre_rst_active", 32'(active), 1);
    rst_n = 1'b0;
    #2;
    check("arst_live",   32'(bullet_live), 0);
    check("arst_x",      32'(bullet_x), 0);
    check("arst_y",      32'(bullet_y), 0);
    check("arst_active", 32'(active), 0);
    check("arst_pixel",  32'(pixel), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    fire = 1'b1; fsync = 1'b1; tick(); fsync = 1'b0; fire = 1'b0;
    check("post_rst_live", 32'(bullet_live), 1);
    check("post_rst_y",    32'(bullet_y), Y0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bullet.md
BULLET -- requirements
Module: bullet

Interface
REQ-001 SHALL provide parameter BULLET_W, default 4, meaning bullet width in pixels (even).
REQ-002 SHALL provide parameter BULLET_H, default 12, meaning bullet height in pixels.
REQ-003 SHALL provide parameter BULLET_SPEED, default 8, meaning upward pixels per frame.
REQ-004 SHALL provide parameter COOLDOWN, default 15, meaning frames between bullet retirement and the next allowed launch.
REQ-005 SHALL have port pixel_clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port fsync, input, 1, one-cycle frame-start pulse.
REQ-008 SHALL have port hpos, input, signed 12, current raster x.
REQ-009 SHALL have port vpos, input, signed 12, current raster y.
REQ-010 SHALL have port fire, input, 1, fire button, already synchronous to pixel_clk.
REQ-011 SHALL have port paddle_center_x, input, signed 12, player x from the paddle block.
REQ-012 SHALL have port hit, input, 1, collision pulse from enemy logic.
REQ-013 SHALL have port pixel, output, [7:0] x3 ([2]=R, [1]=G, [0]=B), bullet colour.
REQ-014 SHALL have port active, output, 1, bullet covers the current pixel.
REQ-015 SHALL have ports bullet_x and bullet_y, output, signed 12 each, bullet centre x and top y.
REQ-016 SHALL have port bullet_live, output, 1, bullet in flight.

Function
REQ-017 SHALL implement FSM states IDLE, FLYING and COOLDOWN; all position and state updates other than hit handling SHALL occur only in fsync cycles.
REQ-018 SHALL set fire_req on a rising edge of fire in IDLE, SHALL clear it in FLYING or COOLDOWN (no queuing), and SHALL consume it on the next fsync.
REQ-019 A fire rising edge in the same cycle as fsync in IDLE SHALL launch on that fsync.
REQ-020 On launch, SHALL load bullet_x <= paddle_center_x and bullet_y <= Y0 = VRES - PADDLE_H - BULLET_H, then enter FLYING; bullet_live SHALL assert the next cycle.
REQ-021 On fsync in FLYING: if bullet_y < BULLET_SPEED, SHALL enter COOLDOWN; otherwise bullet_y <= bullet_y - BULLET_SPEED. bullet_x SHALL stay frozen in flight.
REQ-022 hit in any cycle while FLYING SHALL enter COOLDOWN on the next edge; hit wins over a simultaneous fsync; hit outside FLYING SHALL be ignored.
REQ-023 On entering COOLDOWN, SHALL load the frame counter with COOLDOWN and decrement it per fsync; on fsync with counter = 0 it SHALL enter IDLE.
REQ-024 bullet_live SHALL be 1 exactly when the state is FLYING.
REQ-025 active SHALL be registered with 1-cycle latency: bullet_live && bullet_x - BULLET_W/2 <= hpos < bullet_x + BULLET_W/2 && bullet_y <= vpos < bullet_y + BULLET_H.
REQ-026 Bounds SHALL be computed at 13-bit signed so edge x values (0, HRES-1) do not wrap.
REQ-027 pixel SHALL be {FF,FF,00} when active, else {00,00,00}, registered in the same cycle as active.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, fire_req=0, counter=0, bullet_x=0, bullet_y=0, bullet_live=0, active=0, pixel=0, and the fire edge register to 0.
REQ-029 Reset mid-flight SHALL drop the bullet immediately, with no cooldown after release.

Structure
REQ-030 Package params SHALL hold BULLET_W, BULLET_H, BULLET_SPEED and COOLDOWN defaults and the state enum typedef; VRES, PADDLE_H and HRES SHALL come from params.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Fire pulse with paddle_center_x=320, then fsync -> bullet_live=1, bullet_x=320, bullet_y=Y0.
REQ-033 Free flight -> bullet_y decreases by 8 per fsync; retires on the first fsync with bullet_y<8; live spans floor(Y0/8)+1 frames.
REQ-034 Fire held high and re-pulsed during FLYING and COOLDOWN -> no second launch; a new launch only after 16 fsyncs post-retirement plus a fresh edge.
REQ-035 hit and fsync in the same cycle -> COOLDOWN, bullet_y unchanged.
REQ-036 Raster at hpos=bullet_x-2, vpos=bullet_y -> active=1, pixel=FF,FF,00 one cycle later; hpos=bullet_x+2 -> active=0.
REQ-037 rst_n low mid-flight -> all outputs 0 asynchronously; fire+fsync after release -> launches immediately.
